// File: rtl/share_load_if.sv
// Channel bundle for the share load sequencer: data column in, RNG masks in, shares out.
// Signal suffixes are named from the sequencer's side of the link.
interface share_load_if #(
  parameter int unsigned PAR      = 1,
  parameter int unsigned D        = 2,
  parameter int unsigned COL_SIZE = 5,
  parameter int unsigned NUM_COLS = 64
);
  localparam int unsigned W       = COL_SIZE * PAR;
  localparam int unsigned SW      = (D + 1) * W;
  localparam int unsigned N_BEATS = NUM_COLS / PAR;
  localparam int unsigned CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  logic [W-1:0]   data_i;
  logic           data_valid_i;
  logic           data_ready_o;
  logic [D*W-1:0] rnd_i;
  logic           rnd_valid_i;
  logic           rnd_ready_o;
  logic [SW-1:0]  share_o;
  logic           share_valid_o;
  logic           share_ready_i;
  logic           share_last_o;
  logic [CW-1:0]  beat_idx_o;

  modport slave (
    input  data_i, data_valid_i, rnd_i, rnd_valid_i, share_ready_i,
    output data_ready_o, rnd_ready_o, share_o, share_valid_o, share_last_o, beat_idx_o
  );

  modport master (
    output data_i, data_valid_i, rnd_i, rnd_valid_i, share_ready_i,
    input  data_ready_o, rnd_ready_o, share_o, share_valid_o, share_last_o, beat_idx_o
  );
endinterface

// File: rtl/share_load_sequencer.sv
// Streams one value column by column into (D+1)-share masked form, pairing every
// column with one fresh RNG word; shares are held in a single registered output slot.
module share_load_sequencer #(
  parameter int unsigned PAR      = 1,
  parameter int unsigned D        = 2,
  parameter int unsigned COL_SIZE = 5,
  parameter int unsigned NUM_COLS = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  share_load_if.slave  bus,
  output logic         busy_o,
  output logic         done_o
);
  localparam int unsigned W       = COL_SIZE * PAR;
  localparam int unsigned SW      = (D + 1) * W;
  localparam int unsigned N_BEATS = NUM_COLS / PAR;
  localparam int unsigned CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] beat_idx_q, beat_idx_d;
  logic [SW-1:0] share_q, share_d;
  logic          share_valid_q, share_valid_d;
  logic          share_last_q, share_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          out_free_c;
  logic          accept_c;
  logic          last_beat_c;
  logic [W-1:0]  masked_c;

  // Share 0 carries the data XORed with every mask of this beat.
  always_comb begin
    masked_c = bus.data_i;
    for (int unsigned i = 0; i < D; i++) begin
      masked_c = masked_c ^ bus.rnd_i[i*W +: W];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    beat_idx_d    = beat_idx_q;
    share_d       = share_q;
    share_valid_d = share_valid_q;
    share_last_d  = share_last_q;

    out_free_c  = !share_valid_q || bus.share_ready_i;
    accept_c    = (state_q == RUN) && !abort_i && bus.data_valid_i &&
                  bus.rnd_valid_i && out_free_c;
    last_beat_c = (cnt_q == CW'(N_BEATS - 1));

    // Abort wipes the share register so no masked residue survives.
    if (abort_i && (state_q != IDLE)) begin
      state_d       = IDLE;
      cnt_d         = '0;
      beat_idx_d    = '0;
      share_d       = '0;
      share_valid_d = 1'b0;
      share_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (accept_c) begin
            share_d       = {bus.rnd_i, masked_c};
            share_valid_d = 1'b1;
            beat_idx_d    = cnt_q;
            share_last_d  = last_beat_c;
            cnt_d         = last_beat_c ? '0 : cnt_q + CW'(1);
            if (last_beat_c) begin
              state_d = DRAIN;
            end
          end else if (bus.share_ready_i) begin
            share_valid_d = 1'b0;
            share_last_d  = 1'b0;
          end
        end
        DRAIN: begin
          if (share_valid_q && bus.share_ready_i) begin
            share_valid_d = 1'b0;
            share_last_d  = 1'b0;
            state_d       = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      beat_idx_q    <= '0;
      share_q       <= '0;
      share_valid_q <= 1'b0;
      share_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_idx_q    <= beat_idx_d;
      share_q       <= share_d;
      share_valid_q <= share_valid_d;
      share_last_q  <= share_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Both input channels are consumed together so a mask is never orphaned.
  assign bus.data_ready_o  = accept_c;
  assign bus.rnd_ready_o   = accept_c;
  assign bus.share_o       = share_q;
  assign bus.share_valid_o = share_valid_q;
  assign bus.share_last_o  = share_last_q;
  assign bus.beat_idx_o    = beat_idx_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
endmodule

// File: doc/share_load_sequencer.md
Name: share_load_sequencer

Overview:
- Controller that streams one sensitive value, column by column, into masked (d+1)-share form for the masked Ascon permutation.
- Per beat it pairs one unmasked data column with one fresh d-mask word from the RNG and forms shares in the team's share order.
- Shares are held in a single output register with a valid/ready handshake. It counts beats, flags the last one, and signals completion.
- Each RNG word is consumed exactly once. No mask is ever reused.

Parameters:
- PAR, 1: columns processed per beat (from ascon_params).
- d, 2: masking order; d+1 shares (from ascon_params).
- COL_SIZE, 5: bits per column (from ascon_params).
- NUM_COLS, 64: columns per load; must be a multiple of PAR.
- N_BEATS, NUM_COLS/PAR: derived localparam; CW = $clog2(N_BEATS) (minimum 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  begin a load; honoured only in IDLE.
- abort_i  in  1  synchronous flush to IDLE.
- data_i  in  COL_SIZE*PAR  unmasked column(s).
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  data_i accepted this cycle.
- rnd_i  in  d*COL_SIZE*PAR  fresh masks; mask i = rnd_i[i*W +: W], with W = COL_SIZE*PAR.
- rnd_valid_i  in  1  rnd_i valid.
- rnd_ready_o  out  1  rnd_i accepted this cycle.
- share_o  out  (d+1)*COL_SIZE*PAR  registered shares.
- share_valid_o  out  1  share_o valid.
- share_ready_i  in  1  downstream takes share_o.
- share_last_o  out  1  share_o is the final beat.
- beat_idx_o  out  CW  beat index of share_o.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset is synchronous: rst_ni low at a clk_i edge forces state IDLE and clears every output to 0. This includes share_o, share_valid_o, share_last_o, beat_idx_o, busy_o and done_o. Reset mid-load discards everything.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 → RUN, beat counter cnt=0.
  - Both readies are 0.
- RUN:
  - out_free = !share_valid_o | share_ready_i.
  - accept = data_valid_i & rnd_valid_i & out_free.
  - data_ready_o = rnd_ready_o = accept. Both handshakes always fire together; one is never consumed without the other.
  - On accept, registered next cycle:
    - share_o[(i+1)*W +: W] = mask i, for i = 0..d-1.
    - share_o[0 +: W] = data_i XOR all d masks.
    - share_valid_o = 1; beat_idx_o = cnt; share_last_o = (cnt == N_BEATS-1).
    - cnt increments.
  - Latency from accept to share_valid_o is 1 cycle. Full throughput is 1 beat/cycle when share_ready_i is held high.
  - If share_ready_i=1 and there is no accept, share_valid_o clears.
  - Accept of beat N_BEATS-1 → DRAIN.
- DRAIN:
  - No accepts.
  - When share_valid_o & share_ready_i: share_valid_o → 0, share_last_o → 0, go to DONE.
- DONE:
  - done_o = 1 for exactly this cycle, then IDLE.
  - start_i in the DONE cycle is ignored.
- Output stability: while share_valid_o=1 and share_ready_i=0, share_o, beat_idx_o and share_last_o hold unchanged.
- abort_i (in any state other than IDLE) has priority over all other events:
  - Next state IDLE; share_valid_o, share_last_o, cnt and busy_o cleared.
  - share_o is zeroed so no share residue remains.
  - No done_o pulse.
  - Readies are 0 in the abort cycle.
- start_i while busy is ignored.
- Counter wrap: cnt never exceeds N_BEATS-1 and is reset at start.
- Combinational paths:
  - Readies depend on the other channel's valid and on share_ready_i. This is permitted.
  - Valids never depend on the readies.

Test Plan:
- Single beat (PAR=1, d=2, NUM_COLS=1): start; data_i=5'h1B, rnd_i={5'h0A,5'h15}, both valid → next cycle share_o=15'h2AA4, share_valid_o=1, share_last_o=1, beat_idx_o=0. Take it → DONE, done_o pulses 1 cycle, then busy_o=0.
- Handshake pairing (NUM_COLS=4): rnd_valid_i low for 3 cycles while data_valid_i is high → data_ready_o=0 throughout. No beat is produced until both are valid. 4 beats are emitted with idx 0..3, and last=1 only on idx 3.
- Backpressure: hold share_ready_i=0 for 5 cycles with a beat pending → share_o stable and no inputs accepted. Release → back-to-back beats at 1 per cycle. Check that XOR of all shares equals data for every beat.
- Abort mid-load at beat 2 of 4 with share_valid_o=1 → next cycle IDLE, share_valid_o=0, share_o=0, no done_o. A following start runs a full 4 beats from idx 0.
- Reset mid-DRAIN (rst_ni=0 for 1 cycle) → all outputs 0 after the edge. start_i during busy and during the DONE cycle is ignored (no extra load).
